// File: rtl/adder_error_monitor.sv
// Error-statistics stage behind an approximate OP_W+OP_W adder. It recomputes the exact
// sum of each accepted sample and accumulates count, error, bias and max figures per run.
module adder_error_monitor #(
    parameter int OP_W      = 16,
    parameter int N_SAMPLES = 1024,
    parameter int CNT_W     = 32,
    parameter int ACC_W     = 48
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OP_W-1:0]  a_i,
    input  logic [OP_W-1:0]  b_i,
    input  logic [OP_W:0]    approx_sum_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] sample_count_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [ACC_W-1:0] sum_abs_err_o,
    output logic [ACC_W-1:0] sum_err_o,
    output logic [OP_W:0]    max_abs_err_o
);

    // Counters must hold N_SAMPLES without wrapping; sum_err must hold a sign-extended error.
    if (N_SAMPLES < 1 || CNT_W < $clog2(N_SAMPLES + 1) || ACC_W < OP_W + 2) begin : g_param_check
        $error("adder_error_monitor: illegal parameter combination");
    end

    // state | meaning
    // IDLE  | waiting for start, stats hold last cleared/reset values
    // RUN   | accepting samples until N_SAMPLES have been taken
    // DRAIN | pipeline emptying into the stats, no new samples
    // DONE  | stats final and frozen, done asserted
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [1:0]       drain_q, drain_d;
    logic             accept;
    logic             clear_stats;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            drain_q  <= drain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        drain_d  = drain_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (clear_stats) begin
                    state_d  = ST_RUN;
                    remain_d = CNT_W'(N_SAMPLES);
                end
            end
            ST_RUN: begin
                if (accept) begin
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                        drain_d = 2'd2;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == 2'd0) state_d = ST_DONE;
                else                 drain_d = drain_q - 2'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == ST_RUN);
        busy_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done_o      = (state_q == ST_DONE);
        clear_stats = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    assign accept = in_valid_i && in_ready_o;

    logic [OP_W+1:0] s1_d;
    logic [OP_W+1:0] s1_d_q, s1_neg_d;
    logic [OP_W+1:0] s2_d_q;
    logic [OP_W:0]   s1_ad, s2_ad_q;
    logic            s1_valid_q, s2_valid_q;

    // Signed error in OP_W+2 bits: the exact sum never exceeds OP_W+1 bits.
    assign s1_d     = {1'b0, approx_sum_i} - ({2'b00, a_i} + {2'b00, b_i});
    assign s1_neg_d = -s1_d_q;
    assign s1_ad    = s1_d_q[OP_W+1] ? s1_neg_d[OP_W:0] : s1_d_q[OP_W:0];

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_stats) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            s2_valid_q <= s1_valid_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) s1_d_q <= s1_d;
        if (s1_valid_q) begin
            s2_d_q  <= s1_d_q;
            s2_ad_q <= s1_ad;
        end
    end

    logic [CNT_W-1:0] sample_count_q, err_count_q;
    logic [ACC_W-1:0] sum_abs_q, sum_abs_d, sum_err_q, sum_err_d;
    logic [OP_W:0]    max_q, max_d;
    logic [ACC_W:0]   abs_sum, err_sum;

    always_comb begin
        abs_sum   = {1'b0, sum_abs_q} + {{(ACC_W-OP_W){1'b0}}, s2_ad_q};
        err_sum   = {sum_err_q[ACC_W-1], sum_err_q}
                  + {{(ACC_W-OP_W-1){s2_d_q[OP_W+1]}}, s2_d_q};
        sum_abs_d = abs_sum[ACC_W] ? '1 : abs_sum[ACC_W-1:0];
        if (err_sum[ACC_W] != err_sum[ACC_W-1])
            sum_err_d = err_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sum_err_d = err_sum[ACC_W-1:0];
        max_d = (s2_ad_q > max_q) ? s2_ad_q : max_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_stats) begin
            sample_count_q <= '0;
            err_count_q    <= '0;
            sum_abs_q      <= '0;
            sum_err_q      <= '0;
            max_q          <= '0;
        end else if (s2_valid_q) begin
            sample_count_q <= sample_count_q + CNT_W'(1);
            err_count_q    <= err_count_q + CNT_W'(s2_d_q != '0);
            sum_abs_q      <= sum_abs_d;
            sum_err_q      <= sum_err_d;
            max_q          <= max_d;
        end
    end

    assign sample_count_o = sample_count_q;
    assign err_count_o    = err_count_q;
    assign sum_abs_err_o  = sum_abs_q;
    assign sum_err_o      = sum_err_q;
    assign max_abs_err_o  = max_q;

endmodule

// File: tb/tb_adder_error_monitor.sv
// Bench for adder_error_monitor: three instances (N=4, N=16, N=8 with narrow accumulators)
// share data inputs; sel picks the instance under test.
`timescale 1ns/1ps
module tb_adder_error_monitor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  start_v;
    logic        in_valid;
    logic [15:0] a, b;
    logic [16:0] approx;
    int          sel;

    logic        rdy4, busy4, done4, rdy16, busy16, done16, rdy8, busy8, done8;
    logic [31:0] cnt4, err4, cnt16, err16, cnt8, err8;
    logic [47:0] abs4, serr4, abs16, serr16;
    logic [17:0] abs8, serr8;
    logic [16:0] max4, max16, max8;

    adder_error_monitor #(.N_SAMPLES(4)) u4 (
        .clk_i(clk), .rst_i(rst), .start_i(start_v[0]), .in_valid_i(in_valid),
        .in_ready_o(rdy4), .a_i(a), .b_i(b), .approx_sum_i(approx),
        .busy_o(busy4), .done_o(done4), .sample_count_o(cnt4), .err_count_o(err4),
        .sum_abs_err_o(abs4), .sum_err_o(serr4), .max_abs_err_o(max4));

    adder_error_monitor #(.N_SAMPLES(16)) u16 (
        .clk_i(clk), .rst_i(rst), .start_i(start_v[1]), .in_valid_i(in_valid),
        .in_ready_o(rdy16), .a_i(a), .b_i(b), .approx_sum_i(approx),
        .busy_o(busy16), .done_o(done16), .sample_count_o(cnt16), .err_count_o(err16),
        .sum_abs_err_o(abs16), .sum_err_o(serr16), .max_abs_err_o(max16));

    adder_error_monitor #(.N_SAMPLES(8), .ACC_W(18)) u8s (
        .clk_i(clk), .rst_i(rst), .start_i(start_v[2]), .in_valid_i(in_valid),
        .in_ready_o(rdy8), .a_i(a), .b_i(b), .approx_sum_i(approx),
        .busy_o(busy8), .done_o(done8), .sample_count_o(cnt8), .err_count_o(err8),
        .sum_abs_err_o(abs8), .sum_err_o(serr8), .max_abs_err_o(max8));

    logic   m_ready, m_busy, m_done;
    longint m_count, m_err, m_abs, m_serr, m_max;

    always_comb begin
        m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        m_count = 0; m_err = 0; m_abs = 0; m_serr = 0; m_max = 0;
        case (sel)
            0: begin
                m_ready = rdy4; m_busy = busy4; m_done = done4;
                m_count = {32'b0, cnt4}; m_err = {32'b0, err4}; m_max = {47'b0, max4};
                m_abs = {16'b0, abs4}; m_serr = {{16{serr4[47]}}, serr4};
            end
            1: begin
                m_ready = rdy16; m_busy = busy16; m_done = done16;
                m_count = {32'b0, cnt16}; m_err = {32'b0, err16}; m_max = {47'b0, max16};
                m_abs = {16'b0, abs16}; m_serr = {{16{serr16[47]}}, serr16};
            end
            default: begin
                m_ready = rdy8; m_busy = busy8; m_done = done8;
                m_count = {32'b0, cnt8}; m_err = {32'b0, err8}; m_max = {47'b0, max8};
                m_abs = {46'b0, abs8}; m_serr = {{46{serr8[17]}}, serr8};
            end
        endcase
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic start_run();
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v = '0;
    endtask

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [16:0] sv);
        int guard = 0;
        while (!m_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!m_ready) check("ready_wait", m_ready, 1);
        a = av; b = bv; approx = sv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int guard = 0;
        while (!m_done && guard < budget) begin
            @(negedge clk);
            guard++;
        end
        check("done_wait", m_done, 1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] s;
    } sample_t;

    sample_t sq[$];
    int      ready_viol;

    always @(posedge clk)
        if (sel == 1 && !rst && in_valid && m_ready)
            sq.push_back('{a: a, b: b, s: approx});

    always @(negedge clk)
        if (sel == 1 && sq.size() >= 16 && m_ready) ready_viol++;

    // Reference statistics from the accepted-sample list, 48-bit accumulator limits.
    function automatic void model(output longint cnt, output longint err, output longint sabs,
                                  output longint serr, output longint mx);
        longint d, ad;
        longint abs_max = (longint'(1) << 48) - 1;
        longint pos_max = (longint'(1) << 47) - 1;
        longint neg_min = -(longint'(1) << 47);
        cnt = 0; err = 0; sabs = 0; serr = 0; mx = 0;
        foreach (sq[i]) begin
            d  = longint'(sq[i].s) - (longint'(sq[i].a) + longint'(sq[i].b));
            ad = (d < 0) ? -d : d;
            cnt++;
            if (d != 0) err++;
            sabs = sabs + ad;
            if (sabs > abs_max) sabs = abs_max;
            serr = serr + d;
            if (serr > pos_max) serr = pos_max;
            if (serr < neg_min) serr = neg_min;
            if (ad > mx) mx = ad;
        end
    endfunction

    typedef struct {
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [3:0][16:0] s;
        longint err, sabs, serr, mx;
    } run_vec_t;

    run_vec_t tbl[4];

    initial begin
        longint e_cnt, e_err, e_abs, e_serr, e_max;
        bit     pulsed;

        tbl[0].a = '0; tbl[0].b = '0; tbl[0].s = '0;
        tbl[0].err = 0; tbl[0].sabs = 0; tbl[0].serr = 0; tbl[0].mx = 0;

        tbl[1].a = {16'h0, 16'h0, 16'h8000, 16'h8000};
        tbl[1].b = {16'h0, 16'h0, 16'h8000, 16'h8000};
        tbl[1].s = '0;
        tbl[1].err = 2; tbl[1].sabs = 131072; tbl[1].serr = -131072; tbl[1].mx = 65536;

        tbl[2].a = {16'd0, 16'd0, 16'd3, 16'd1};
        tbl[2].b = {16'd0, 16'd0, 16'd4, 16'd1};
        tbl[2].s = {17'h0, 17'h0, 17'h00007, 17'h18000};
        tbl[2].err = 1; tbl[2].sabs = 98302; tbl[2].serr = 98302; tbl[2].mx = 98302;

        tbl[3].a = {16'h0000, 16'h0005, 16'hFFFF, 16'hFFFF};
        tbl[3].b = {16'h0000, 16'h0005, 16'h0000, 16'hFFFF};
        tbl[3].s = {17'h1FFFF, 17'h00009, 17'h00000, 17'h1FFFF};
        tbl[3].err = 4; tbl[3].sabs = 196608; tbl[3].serr = 65536; tbl[3].mx = 131071;

        sel = 0; rst = 1'b1; start_v = '0; in_valid = 1'b0; a = '0; b = '0; approx = '0;
        ready_viol = 0;

        // T1: reset state, then start
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", m_ready, 0);
        check("rst_busy", m_busy, 0);
        check("rst_done", m_done, 0);
        check("rst_count", m_count, 0);
        check("rst_err", m_err, 0);
        check("rst_abs", m_abs, 0);
        check("rst_serr", m_serr, 0);
        check("rst_max", m_max, 0);
        start_run();
        check("start_ready", m_ready, 1);
        check("start_busy", m_busy, 1);

        // two-edge latency of a single sample, then abort with rst
        a = 16'd1; b = 16'd2; approx = 17'd4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_t0", m_count, 0);
        @(negedge clk);
        check("lat_t1", m_count, 0);
        @(negedge clk);
        check("lat_t2_count", m_count, 1);
        check("lat_t2_err", m_err, 1);
        check("lat_t2_serr", m_serr, 1);
        check("lat_t2_max", m_max, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", m_ready, 0);
        check("abort_count", m_count, 0);

        // T2-T4 style runs from the table, with done timing
        for (int i = 0; i < 4; i++) begin
            start_run();
            for (int k = 0; k < 4; k++) send(tbl[i].a[k], tbl[i].b[k], tbl[i].s[k]);
            check("drain_ready", m_ready, 0);
            check("drain_busy", m_busy, 1);
            @(negedge clk);
            @(negedge clk);
            check("done_early", m_done, 0);
            @(negedge clk);
            check("done_tN3", m_done, 1);
            check("done_busy", m_busy, 0);
            check("tbl_count", m_count, 4);
            check("tbl_err", m_err, tbl[i].err);
            check("tbl_abs", m_abs, tbl[i].sabs);
            check("tbl_serr", m_serr, tbl[i].serr);
            check("tbl_max", m_max, tbl[i].mx);
        end

        // T5: random sparse traffic, mid-run start ignored
        sel = 1;
        sq.delete();
        ready_viol = 0;
        pulsed = 1'b0;
        start_run();
        for (int cyc = 0; cyc < 3000 && !m_done; cyc++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            approx = ($urandom_range(0, 2) == 0) ? 17'($urandom) : ({1'b0, a} + {1'b0, b});
            in_valid = ($urandom_range(0, 99) < 30);
            start_v[1] = (!pulsed && cyc >= 8 && sq.size() < 12);
            if (start_v[1]) pulsed = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start_v = '0;
        check("t5_done", m_done, 1);
        check("t5_accepts", sq.size(), 16);
        check("t5_ready_after_last", ready_viol, 0);
        model(e_cnt, e_err, e_abs, e_serr, e_max);
        check("t5_count", m_count, e_cnt);
        check("t5_err", m_err, e_err);
        check("t5_abs", m_abs, e_abs);
        check("t5_serr", m_serr, e_serr);
        check("t5_max", m_max, e_max);

        // T6: saturation with 18-bit accumulators, then rst mid-run
        sel = 2;
        start_run();
        for (int k = 0; k < 8; k++) send(16'd0, 16'd0, 17'h10000);
        wait_done(50);
        check("t6_count", m_count, 8);
        check("t6_err", m_err, 8);
        check("t6_abs_sat", m_abs, 262143);
        check("t6_serr_sat", m_serr, 131071);
        check("t6_max", m_max, 65536);

        start_run();
        a = 16'd0; b = 16'd0; approx = 17'h10000; in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t6_pre_rst_count", m_count, 1);
        check("t6_pre_rst_ready", m_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_ready", m_ready, 0);
        check("t6_rst_busy", m_busy, 0);
        check("t6_rst_done", m_done, 0);
        check("t6_rst_count", m_count, 0);
        check("t6_rst_err", m_err, 0);
        check("t6_rst_abs", m_abs, 0);
        check("t6_rst_serr", m_serr, 0);
        check("t6_rst_max", m_max, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t6_post_rst_count", m_count, 0);
        end
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
